cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 NUM_REQ, 3, number of functional units sharing the common data bus (0=ALU, 1=LSU, 2=BRU).
REQ-002 NAME_W, 5, architectural register name width (matches `NameBus`).
REQ-003 DATA_W, 32, result data width (matches `DataBus`).
REQ-004 TAG_W, 4, rename tag width (matches `TagBus`).
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  pipeline flush (branch mispredict); kills pending and in-flight broadcasts.
REQ-008 req_valid  in  NUM_REQ  per-unit result ready to broadcast.
REQ-009 req_name  in  NUM_REQ*NAME_W  per-unit destination register, unit i at bits [i*NAME_W +: NAME_W].
REQ-010 req_data  in  NUM_REQ*DATA_W  per-unit result data, same packing.
REQ-011 req_tag  in  NUM_REQ*TAG_W  per-unit rename tag, same packing.
REQ-012 req_ready  out  NUM_REQ  one-hot-or-zero grant; transfer when req_valid[i] & req_ready[i].
REQ-013 cdb_en  out  1  broadcast valid (drives register file enCDBWrt and reservation stations).
REQ-014 cdb_name  out  NAME_W  broadcast destination name.
REQ-015 cdb_data  out  DATA_W  broadcast data.
REQ-016 cdb_tag  out  TAG_W  broadcast tag.
REQ-017 cdb_src  out  2  index of unit that produced the current broadcast (debug/stats).

Function
REQ-018 At most one transfer per cycle; req_ready combinational from req_valid, flush, rr_ptr; at most one bit set.
REQ-019 Round-robin: search order rr_ptr, rr_ptr+1, ... mod NUM_REQ; first valid unit is granted.
REQ-020 After a transfer from unit g, rr_ptr <= (g+1) mod NUM_REQ; with no transfer rr_ptr holds.
REQ-021 No valid requester -> req_ready all zero, rr_ptr unchanged, cdb_en low next cycle.
REQ-022 Latency exactly 1: payload accepted at edge N appears on cdb_* with cdb_en=1 during cycle N+1 only.
REQ-023 CDB has no backpressure; cdb_en is a single-cycle pulse per accepted transfer; back-to-back transfers give continuous cdb_en.
REQ-024 cdb_name/data/tag/src update only on transfer; hold last value when cdb_en low.
REQ-025 Ungranted requester must hold req_valid and payload stable; arbiter shall not drop or reorder an accepted result.
REQ-026 Name 0 results are broadcast unchanged (tag must still be released to consumers); register file ignores data write.
REQ-027 flush=1: req_ready all zero that cycle, cdb_en=0 next cycle, rr_ptr reset to 0; a broadcast already on cdb_en in the flush cycle still completes.
REQ-028 Starvation bound: any unit holding req_valid is granted within NUM_REQ cycles absent flush/rst.

Reset
REQ-029 rst=1 at posedge: cdb_en=0, cdb_name=0, cdb_data=0, cdb_tag=`tagFree`, cdb_src=0, rr_ptr=0.
REQ-030 During rst, req_ready all zero; transfer in the reset cycle is discarded.
REQ-031 rst has priority over flush and over any transfer.

Structure
REQ-032 NameBus, DataBus, TagBus, tagFree, Enable, and unit-index constants live in shared defines.v.
REQ-033 Round-robin pick logic in one sub-module cdb_rr_pick (inputs valid vector, ptr; outputs one-hot grant, index).
REQ-034 Output stage is a single register bank in cdb_arbiter; no FIFO.

Verification
REQ-035 Single: unit1 valid, name=7, data=0xDEADBEEF, tag=3 at cycle 0 -> req_ready=010 cycle 0; cdb_en=1, name=7, data=0xDEADBEEF, tag=3, src=1 cycle 1 only.
REQ-036 Contention: all three valid continuously from rr_ptr=0 -> grants 0,1,2,0 on consecutive cycles; cdb_en high continuously from cycle 1.
REQ-037 Pointer skip: rr_ptr=1, only units 0 and 2 valid -> unit 2 granted, then unit 0; rr_ptr ends at 1.
REQ-038 Flush: units 0,2 valid, flush=1 cycle 5 -> req_ready=000 cycle 5, cdb_en=0 cycle 6, rr_ptr=0; cycle-4 grant still broadcast in cycle 5.
REQ-039 Reset mid-stream: rst=1 while unit 2 granted -> cdb_en=0, cdb_tag=tagFree next cycle; unit 2 granted again after rst deasserts.
REQ-040 Name zero: unit0 name=0, tag=5 -> cdb_en=1, cdb_name=0, cdb_tag=5 one cycle later.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared bus widths, tag constants and unit indices for the CDB arbiter
package cdb_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int NAME_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int IDX_W   = 2;

  typedef logic [NAME_W-1:0] name_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Tag value meaning "no producer"; consumers ignore a broadcast carrying it.
  localparam tag_t TAG_FREE = '0;
  localparam logic ENABLE   = 1'b1;

  localparam idx_t UNIT_ALU = 2'd0;
  localparam idx_t UNIT_LSU = 2'd1;
  localparam idx_t UNIT_BRU = 2'd2;

  // Successor of a unit index in round-robin order, wrapping at NUM_REQ.
  function automatic idx_t next_idx(input idx_t i);
    return (int'(i) + 1 >= NUM_REQ) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - round-robin first-valid picker starting at a pointer
module cdb_rr_pick
  import cdb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  idx_t               ptr,
  output logic [NUM_REQ-1:0] grant,
  output idx_t               idx,
  output logic               any
);

  // Walk ptr, ptr+1, ... modulo NUM_REQ; the first valid unit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && valid[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with one-cycle registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*NAME_W-1:0] req_name,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_en,
  output name_t                     cdb_name,
  output data_t                     cdb_data,
  output tag_t                      cdb_tag,
  output logic [1:0]                cdb_src
);

  idx_t               rr_ptr;
  idx_t               pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               xfer;

  cdb_rr_pick u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Reset and flush both block the handshake so nothing is accepted and lost.
  assign xfer      = pick_any & ~rst & ~flush;
  assign req_ready = xfer ? pick_grant : '0;

  // Output register bank: capture the granted payload, advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_en   <= 1'b0;
      cdb_name <= '0;
      cdb_data <= '0;
      cdb_tag  <= TAG_FREE;
      cdb_src  <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      cdb_en <= 1'b0;
      rr_ptr <= '0;
    end else begin
      cdb_en <= xfer;
      if (xfer) begin
        cdb_name <= req_name[pick_idx*NAME_W +: NAME_W];
        cdb_data <= req_data[pick_idx*DATA_W +: DATA_W];
        cdb_tag  <= req_tag[pick_idx*TAG_W +: TAG_W];
        cdb_src  <= pick_idx;
        rr_ptr   <= next_idx(pick_idx);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - vector table and scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*NAME_W-1:0] req_name;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_en;
  name_t                     cdb_name;
  data_t                     cdb_data;
  tag_t                      cdb_tag;
  logic [1:0]                cdb_src;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_name  (req_name),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .cdb_en    (cdb_en),
    .cdb_name  (cdb_name),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    name_t      name;
    data_t      data;
    tag_t       tag;
    logic [1:0] src;
  } bcast_t;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [2:0] valid;
    logic [2:0] exp_ready;
  } vec_t;

  int errors = 0;
  int checks = 0;

  name_t u_name [NUM_REQ];
  data_t u_data [NUM_REQ];
  tag_t  u_tag  [NUM_REQ];

  bcast_t sb_q [$];
  bcast_t last_b;
  logic   started = 1'b0;
  logic   exp_rst_next = 1'b0;

  vec_t tbl [24];

  task automatic check_cdb(input int step_no);
    bcast_t act, exp;
    act = '{en: cdb_en, name: cdb_name, data: cdb_data, tag: cdb_tag, src: cdb_src};
    if (exp_rst_next) begin
      exp = '{en: 1'b0, name: '0, data: '0, tag: TAG_FREE, src: 2'd0};
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
    end else begin
      exp = last_b;
      exp.en = 1'b0;
    end
    last_b = exp;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cdb step %0d: got en=%0b name=%0d data=%h tag=%0d src=%0d, want en=%0b name=%0d data=%h tag=%0d src=%0d",
               step_no, act.en, act.name, act.data, act.tag, act.src,
               exp.en, exp.name, exp.data, exp.tag, exp.src);
    end
  endtask

  task automatic step(input int step_no, input logic r, input logic f,
                      input logic [2:0] v, input logic [2:0] e);
    bcast_t nb;
    @(negedge clk);
    if (started) check_cdb(step_no);
    started   = 1'b1;
    rst       = r;
    flush     = f;
    req_valid = v;
    req_name  = {u_name[2], u_name[1], u_name[0]};
    req_data  = {u_data[2], u_data[1], u_data[0]};
    req_tag   = {u_tag[2], u_tag[1], u_tag[0]};
    #1;
    checks++;
    if (req_ready !== e) begin
      errors++;
      $display("FAIL ready step %0d: got %b want %b", step_no, req_ready, e);
    end
    if (!r && !f && e != 3'b000) begin
      for (int u = 0; u < NUM_REQ; u++) begin
        if (e[u]) begin
          nb = '{en: 1'b1, name: u_name[u], data: u_data[u], tag: u_tag[u], src: 2'(u)};
          sb_q.push_back(nb);
        end
      end
    end
    exp_rst_next = r;
  endtask

  function automatic logic [2:0] rr_expect(input logic [2:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (p + k) % NUM_REQ;
      if (v[j]) return 3'(1 << j);
    end
    return 3'b000;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] v, e, held;
    logic       f;
    int         mptr;

    rst = 1'b1; flush = 1'b0; req_valid = '0;
    req_name = '0; req_data = '0; req_tag = '0;
    last_b = '0;

    u_name[0] = 5'd0;  u_data[0] = 32'h1234_5678; u_tag[0] = 4'd5;
    u_name[1] = 5'd7;  u_data[1] = 32'hDEAD_BEEF; u_tag[1] = 4'd3;
    u_name[2] = 5'd31; u_data[2] = 32'hA5A5_A5A5; u_tag[2] = 4'd15;

    tbl[0]  = '{rst: 1, flush: 0, valid: 3'b111, exp_ready: 3'b000};
    tbl[1]  = '{rst: 1, flush: 0, valid: 3'b000, exp_ready: 3'b000};
    tbl[2]  = '{rst: 0, flush: 0, valid: 3'b010, exp_ready: 3'b010};
    tbl[3]  = '{rst: 0, flush: 0, valid: 3'b000, exp_ready: 3'b000};
    tbl[4]  = '{rst: 0, flush: 0, valid: 3'b000, exp_ready: 3'b000};
    tbl[5]  = '{rst: 0, flush: 1, valid: 3'b000, exp_ready: 3'b000};
    tbl[6]  = '{rst: 0, flush: 0, valid: 3'b111, exp_ready: 3'b001};
    tbl[7]  = '{rst: 0, flush: 0, valid: 3'b111, exp_ready: 3'b010};
    tbl[8]  = '{rst: 0, flush: 0, valid: 3'b111, exp_ready: 3'b100};
    tbl[9]  = '{rst: 0, flush: 0, valid: 3'b111, exp_ready: 3'b001};
    tbl[10] = '{rst: 0, flush: 0, valid: 3'b101, exp_ready: 3'b100};
    tbl[11] = '{rst: 0, flush: 0, valid: 3'b101, exp_ready: 3'b001};
    tbl[12] = '{rst: 0, flush: 0, valid: 3'b000, exp_ready: 3'b000};
    tbl[13] = '{rst: 0, flush: 0, valid: 3'b011, exp_ready: 3'b010};
    tbl[14] = '{rst: 0, flush: 0, valid: 3'b001, exp_ready: 3'b001};
    tbl[15] = '{rst: 0, flush: 1, valid: 3'b101, exp_ready: 3'b000};
    tbl[16] = '{rst: 0, flush: 0, valid: 3'b101, exp_ready: 3'b001};
    tbl[17] = '{rst: 1, flush: 0, valid: 3'b100, exp_ready: 3'b000};
    tbl[18] = '{rst: 0, flush: 0, valid: 3'b100, exp_ready: 3'b100};
    tbl[19] = '{rst: 0, flush: 0, valid: 3'b000, exp_ready: 3'b000};
    tbl[20] = '{rst: 1, flush: 1, valid: 3'b111, exp_ready: 3'b000};
    tbl[21] = '{rst: 0, flush: 0, valid: 3'b111, exp_ready: 3'b001};
    tbl[22] = '{rst: 0, flush: 0, valid: 3'b000, exp_ready: 3'b000};
    tbl[23] = '{rst: 0, flush: 0, valid: 3'b000, exp_ready: 3'b000};

    for (int i = 0; i < 24; i++)
      step(i, tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].exp_ready);

    // Random traffic: requesters hold valid and payload until granted, occasional flush.
    step(100, 1'b0, 1'b1, 3'b000, 3'b000);
    mptr = 0;
    held = 3'b000;
    for (int c = 0; c < 120; c++) begin
      for (int u = 0; u < NUM_REQ; u++) begin
        if (!held[u]) begin
          v[u] = ($urandom_range(0, 2) != 0);
          u_name[u] = 5'($urandom);
          u_data[u] = $urandom;
          u_tag[u]  = 4'($urandom);
        end else begin
          v[u] = 1'b1;
        end
      end
      f = ($urandom_range(0, 15) == 0);
      e = f ? 3'b000 : rr_expect(v, mptr);
      step(101 + c, 1'b0, f, v, e);
      if (f) begin
        mptr = 0;
      end else begin
        for (int u = 0; u < NUM_REQ; u++)
          if (e[u]) mptr = (u + 1) % NUM_REQ;
      end
      held = v & ~e;
    end

    step(300, 1'b0, 1'b0, 3'b000, 3'b000);
    step(301, 1'b0, 1'b0, 3'b000, 3'b000);
    @(negedge clk);
    check_cdb(302);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
